// File: rtl/hpm_counter_bank.sv
// Machine performance-counter bank: mcycle, minstret and NUM_CNT event counters
// on the CSR read/write port, with sticky overflow flags and an overflow interrupt.

module hpm_cnt_slice #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf_set
);
    logic unused_ok;
    assign unused_ok = ^wdata;

    // A CSR write replaces this cycle's increment, so it can never flag overflow
    assign ovf_set = inc & ~wr_lo & ~wr_hi & (&cnt);

    always_ff @(posedge clk) begin
        if (rst)        cnt <= '0;
        else if (wr_lo) cnt <= {cnt[CNT_W-1:32], wdata};
        else if (wr_hi) cnt <= {wdata[CNT_W-33:0], cnt[31:0]};
        else if (inc)   cnt <= cnt + CNT_W'(1);
    end
endmodule

module hpm_counter_bank #(
    parameter int NUM_CNT = 4,
    parameter int CNT_W   = 64,
    parameter int NUM_EVT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               retire_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic               csr_re,
    input  logic [11:0]        csr_raddr,
    output logic [31:0]        csr_rdata,
    output logic               csr_rhit,
    input  logic               csr_we,
    input  logic [11:0]        csr_waddr,
    input  logic [31:0]        csr_wdata,
    output logic               ovf_irq
);
    localparam int NC = NUM_CNT + 3;
    // Index 1 (time) lives elsewhere; its bit is hardwired 0 in every mask
    localparam logic [NC-1:0] CMASK = ~NC'(2);

    logic [NC-1:0][CNT_W-1:0] cnt_q;
    logic [NC-1:0]            ovf_set;
    logic [NC-1:0]            inh_q, ovf_q, ovf_en_q, ovf_d, ovf_en_d;
    logic [NUM_CNT-1:0][7:0]  evt_sel_q;
    logic [255:0]             evt_ext;
    logic [31:0]              rd_val;
    logic                     rd_hit;
    logic                     unused_ok;

    // Select s picks evt_ext[s]; s=0 and s>NUM_EVT land on constant-0 bits
    assign evt_ext   = {255'(evt_i), 1'b0};
    assign unused_ok = ^{csr_wdata, cnt_q[1]};

    genvar c;
    generate
        for (c = 0; c < NC; c++) begin : g_cnt
            if (c == 1) begin : g_time
                assign cnt_q[c]   = '0;
                assign ovf_set[c] = 1'b0;
            end else begin : g_slice
                logic inc;
                if (c == 0) begin : g_cyc
                    assign inc = 1'b1;
                end else if (c == 2) begin : g_ret
                    assign inc = retire_i;
                end else begin : g_evt
                    assign inc = evt_ext[evt_sel_q[c-3]];
                end
                hpm_cnt_slice #(.CNT_W(CNT_W)) u_slice (
                    .clk     (clk),
                    .rst     (rst),
                    .inc     (inc & ~inh_q[c]),
                    .wr_lo   (csr_we && csr_waddr == 12'(32'hB00 + c)),
                    .wr_hi   (csr_we && csr_waddr == 12'(32'hB80 + c)),
                    .wdata   (csr_wdata),
                    .cnt     (cnt_q[c]),
                    .ovf_set (ovf_set[c])
                );
            end
        end
    endgenerate

    // Overflow set is OR-ed after the W1C so a same-cycle set wins
    always_comb begin
        ovf_en_d = ovf_en_q;
        if (csr_we && csr_waddr == 12'h7C1) ovf_en_d = csr_wdata[NC-1:0] & CMASK;
        ovf_d = ovf_q;
        if (csr_we && csr_waddr == 12'h7C0) ovf_d = ovf_q & ~csr_wdata[NC-1:0];
        ovf_d = (ovf_d | ovf_set) & CMASK;
    end

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (i != 1 && csr_raddr == 12'(32'hB00 + i)) begin
                rd_hit = 1'b1;
                rd_val = cnt_q[i][31:0];
            end
            if (i != 1 && csr_raddr == 12'(32'hB80 + i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(cnt_q[i][CNT_W-1:32]);
            end
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (csr_raddr == 12'(32'h323 + i)) begin
                rd_hit = 1'b1;
                rd_val = 32'(evt_sel_q[i]);
            end
        end
        case (csr_raddr)
            12'h320: begin rd_hit = 1'b1; rd_val = 32'(inh_q);    end
            12'h7C0: begin rd_hit = 1'b1; rd_val = 32'(ovf_q);    end
            12'h7C1: begin rd_hit = 1'b1; rd_val = 32'(ovf_en_q); end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_q     <= '0;
            ovf_q     <= '0;
            ovf_en_q  <= '0;
            evt_sel_q <= '0;
            ovf_irq   <= 1'b0;
            csr_rdata <= '0;
            csr_rhit  <= 1'b0;
        end else begin
            if (csr_we && csr_waddr == 12'h320) inh_q <= csr_wdata[NC-1:0] & CMASK;
            for (int i = 0; i < NUM_CNT; i++)
                if (csr_we && csr_waddr == 12'(32'h323 + i)) evt_sel_q[i] <= csr_wdata[7:0];
            ovf_q    <= ovf_d;
            ovf_en_q <= ovf_en_d;
            ovf_irq  <= |(ovf_d & ovf_en_d);
            if (csr_re) begin
                csr_rdata <= rd_val;
                csr_rhit  <= rd_hit;
            end
        end
    end
endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised machine performance-counter bank for the RV32 core: fixed `mcycle`/`minstret` plus `NUM_CNT` programmable `mhpmcounter` channels with event select, per-counter inhibit, sticky overflow flags and an overflow interrupt. It replaces the hard-wired 64-bit `mcycle_64`/`minstret_64` pair inside `csr` and is accessed through the CSR read/write port. The core's `clk` drives it. Count values are visible to the benches for cycle and IPC measurement.

## Interface
- `NUM_CNT`, 4: programmable counters, 1..29 (`mhpmcounter3`..).
- `CNT_W`, 64: counter width, 33..64; high CSR half holds `CNT_W-32` bits, upper bits read 0.
- `NUM_EVT`, 8: event input count, 1..255.
- `clk` in 1: core clock.
- `rst` in 1: reset, synchronous, active-high.
- `retire_i` in 1: one instruction retired this cycle (from MEM/WB).
- `evt_i` in NUM_EVT: per-cycle event pulses; bit k is event number k+1.
- `csr_re` in 1: read request.
- `csr_raddr` in 12: read address.
- `csr_rdata` out 32: read data, registered.
- `csr_rhit` out 1: registered; 1 if `csr_raddr` mapped in this block.
- `csr_we` in 1: write strobe.
- `csr_waddr` in 12: write address.
- `csr_wdata` in 32: write data.
- `ovf_irq` out 1: registered, `|(ovf & ovf_en)`.

## Operation
- Counter index c: 0 = mcycle, 2 = minstret, 3..2+NUM_CNT = mhpmcounter. Index 1 (time) unmapped.
- Address map: low half 0xB00+c, high half 0xB80+c; `mhpmevent` 0x320+c (c≥3), 8-bit select, upper bits read 0; `mcountinhibit` 0x320, bit c, bit 1 and unmapped bits hardwired 0; `ovf` 0x7C0, bit c, write-1-to-clear; `ovf_en` 0x7C1, bit c, plain RW.
- Increment per cycle: mcycle +1; minstret +`retire_i`; mhpmcounter +1 if select s in 1..NUM_EVT and `evt_i[s-1]`; s=0 or s>NUM_EVT never counts. Inhibit bit c set freezes counter c.
- Arithmetic modulo 2^CNT_W. An increment from all-ones to 0 sets `ovf[c]` (sticky).
- CSR write to counter low half: value = {old_hi, wdata}; high half: value = {wdata[CNT_W-33:0], old_lo}. That cycle's increment is dropped for that counter only; no overflow set.
- Same-cycle overflow-set and W1C on the same `ovf` bit: set wins.
- Writes to unmapped or read-only addresses are ignored. Unmapped reads return 0 with `csr_rhit`=0.
- Read of a counter returns its value before any same-cycle write or increment.

## Timing
- Read latency 1: `csr_re` in cycle n -> `csr_rdata`/`csr_rhit` valid in cycle n+1, held until the next `csr_re`.
- Write takes effect at the cycle-n edge; a read issued in cycle n+1 sees it.
- `ovf_irq` asserts the cycle after the overflowing increment (or `ovf_en` write) and deasserts the cycle after the clearing write.
- Reset: all counters, `mhpmevent`, `mcountinhibit`, `ovf`, `ovf_en` = 0; `csr_rdata` = 0, `csr_rhit` = 0, `ovf_irq` = 0. mcycle reads 1 on the first read issued one cycle after `rst` deasserts.
- Reset mid-operation overrides everything in that cycle, including pending writes and increments.
- No back-pressure. One read and one write per cycle, independent.

## Test plan
- Reset, then idle 10 cycles with `retire_i`=1 on 6 of them; read 0xB00 -> 10 ±fixed offset (1 cycle read latency accounted), read 0xB02 -> 6, `csr_rhit`=1.
- Write 0x323 = 2 and pulse `evt_i[1]` 5 times and `evt_i[0]` 3 times; read 0xB03 -> 5; write 0x323 = 0 and pulse 4 more -> still 5.
- Write 0xB03 = 0xFFFFFFFE, 0xB83 = 0xFFFFFFFF (CNT_W=64), `ovf_en`=0x8, 2 events -> counter 0, `ovf[3]`=1, `ovf_irq`=1 next cycle; write 0x7C0 = 0x8 -> `ovf_irq`=0.
- Set `mcountinhibit`=0x5 for 20 cycles -> mcycle, minstret unchanged; clear -> both resume; bit 1 reads 0 after writing 0x7.
- Write 0xB00 = 0x1234 in a cycle mcycle would increment -> next read 0x1234 + cycles elapsed after the write, high half unchanged; read 0x7FF -> 0, `csr_rhit`=0.
- Assert `rst` mid-count with `ovf_irq`=1 -> all reads return 0, `ovf_irq`=0 the next cycle.
